// File: rtl/l1_stream_out_pkg.sv
// Shared types and constants for the MEM_L1 output streamer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package l1_stream_out_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] CSEL_NONE   = 3'b000;
    localparam logic [2:0] CSEL_MEM_L0 = 3'b001;
    localparam logic [2:0] CSEL_MEM_L1 = 3'b011;

    localparam int L1_NUM_WORDS = 1024;
    localparam int ADDR_W       = 10;
    localparam int DATA_W       = 20;

    typedef logic [DATA_W-1:0] data_t;

    // One buffered beat: pooled Q4.16 word plus its end-of-frame tag.
    typedef struct packed {
        logic  last;
        data_t data;
    } fifo_ent_t;

endpackage

// File: rtl/l1_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head and occupancy count.
// Latency: push visible at the head one cycle later.
// Backpressure: push ignored when full unless a pop frees a slot in the same cycle.
module l1_sync_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/l1_stream_out.sv
// Streams one frame of MEM_L1 words, in address order, onto a valid/ready output.
// Latency: start -> first read next cycle -> first m_valid three cycles after start.
// Backpressure: reads are only issued while buffer occupancy plus in-flight reads < FIFO_DEPTH.
module l1_stream_out
    import l1_stream_out_pkg::*;
#(
    parameter int         NUM_WORDS  = L1_NUM_WORDS,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [2:0] CSEL_L1    = CSEL_MEM_L1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        crd,
    output logic [11:0] caddr_rd,
    output logic [2:0]  csel,
    input  logic [19:0] cdata_rd,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [19:0] m_data,
    output logic        m_last
);

    localparam int                CW       = $clog2(FIFO_DEPTH) + 1;
    localparam int                SW       = CW + 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

    state_t            state;
    state_t            state_nxt;
    logic              issue;
    logic              addr_is_last;
    logic [ADDR_W-1:0] rd_idx;
    logic [ADDR_W-1:0] issue_addr;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        csel_q;
    logic              crd_q;
    logic              crd_last;
    logic              ret_vld;
    logic              ret_last;

    fifo_ent_t         push_ent;
    fifo_ent_t         head_ent;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [CW-1:0]     fifo_count;
    logic [SW-1:0]     committed;
    logic              credit_ok;

    // Reads on the bus (crd_q) and data on the return bus (ret_vld) both hold a slot.
    assign committed    = SW'(fifo_count) + SW'(crd_q) + SW'(ret_vld);
    assign credit_ok    = !fifo_full && (committed < SW'(FIFO_DEPTH));
    assign issue_addr   = (state == ST_IDLE) ? '0 : rd_idx;
    assign addr_is_last = (issue_addr == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    issue     = 1'b1;
                    state_nxt = addr_is_last ? ST_DRAIN : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (addr_is_last) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && !crd_q && !ret_vld) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_idx   <= '0;
            addr_q   <= '0;
            csel_q   <= CSEL_NONE;
            crd_q    <= 1'b0;
            crd_last <= 1'b0;
            ret_vld  <= 1'b0;
            ret_last <= 1'b0;
        end else begin
            crd_q    <= issue;
            csel_q   <= issue ? CSEL_L1 : CSEL_NONE;
            crd_last <= issue && addr_is_last;
            ret_vld  <= crd_q;
            ret_last <= crd_last;
            if (issue) begin
                addr_q <= issue_addr;
                rd_idx <= issue_addr + ADDR_W'(1);
            end
        end
    end

    assign push_ent.data = cdata_rd;
    assign push_ent.last = ret_last;

    l1_sync_fifo #(
        .WIDTH ($bits(fifo_ent_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (ret_vld),
        .push_data (push_ent),
        .pop       (fifo_pop),
        .pop_data  (head_ent),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign crd      = crd_q;
    assign caddr_rd = {2'b00, addr_q};
    assign csel     = csel_q;
    assign m_valid  = !fifo_empty;
    assign fifo_pop = m_valid && m_ready;
    // Head storage is not reset, so the outputs are forced to zero while empty.
    assign m_data   = m_valid ? head_ent.data : '0;
    assign m_last   = m_valid && head_ent.last;

endmodule

// File: tb/tb_l1_stream_out.sv
// Self-checking bench for l1_stream_out against a queue-based frame model.
// Latency: n/a.
// Backpressure: m_ready driven constant, random, or held low per scenario.
module tb_l1_stream_out;

    localparam int NW = 1024;
    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        crd;
    logic [11:0] caddr_rd;
    logic [2:0]  csel;
    logic [19:0] cdata_rd;
    logic        m_valid;
    logic        m_ready;
    logic [19:0] m_data;
    logic        m_last;

    l1_stream_out #(
        .NUM_WORDS  (NW),
        .FIFO_DEPTH (FD),
        .CSEL_L1    (3'b011)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .crd      (crd),
        .caddr_rd (caddr_rd),
        .csel     (csel),
        .cdata_rd (cdata_rd),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last)
    );

    always #5 clk = ~clk;

    // MEM_L1 model: data one cycle after crd, garbage otherwise.
    logic [19:0] mem [NW];
    always @(posedge clk) begin
        cdata_rd <= crd ? mem[caddr_rd[9:0]] : 20'($urandom);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          total;
    int          bad;
    int          fc;
    logic [20:0] expq [$];
    int          exp_rd_addr;
    int          reads;
    int          beats;
    int          dones;
    int          lasts;
    int          early_reads;
    int          first_crd_cyc;
    int          first_beat_cyc;
    int          last_cyc;
    int          done_cyc;
    logic        prev_stall;
    logic [19:0] prev_dat;
    logic        prev_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"},    busy,     0);
        chk({tag, "_done"},    done,     0);
        chk({tag, "_crd"},     crd,      0);
        chk({tag, "_caddr"},   caddr_rd, 0);
        chk({tag, "_csel"},    csel,     0);
        chk({tag, "_m_valid"}, m_valid,  0);
        chk({tag, "_m_data"},  m_data,   0);
        chk({tag, "_m_last"},  m_last,   0);
    endtask

    // Observe one cycle of DUT outputs (called away from the rising edge).
    task automatic sample();
        logic [20:0] e;
        chk("csel", csel, crd ? 32'h3 : 32'h0);
        chk("caddr_hi", caddr_rd[11:10], 0);
        if (prev_stall) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_data",  m_data,  prev_dat);
            chk("stall_last",  m_last,  prev_last);
        end
        if (crd) begin
            if (reads == 0) first_crd_cyc = fc;
            chk("rd_addr", caddr_rd, exp_rd_addr);
            chk("credit", 32'(reads + 1 - beats <= FD), 1);
            exp_rd_addr++;
            reads++;
            if (fc < 20) early_reads++;
        end
        if (m_valid && m_ready) begin
            if (beats == 0) first_beat_cyc = fc;
            if (expq.size() == 0) begin
                chk("beat_count", beats + 1, NW);
            end else begin
                e = expq.pop_front();
                chk("m_data", m_data, e[19:0]);
                chk("m_last", m_last, e[20]);
            end
            if (m_last) begin
                lasts++;
                last_cyc = fc;
            end
            beats++;
        end
        if (done) begin
            dones++;
            done_cyc = fc;
        end
        prev_stall = m_valid && !m_ready;
        prev_dat   = m_data;
        prev_last  = m_last;
    endtask

    // mode 0: ready high; 1: random ready; 2: ready low for the first 20 cycles.
    task automatic frame(input int mode, input int restart, input int budget, input bit expect_done);
        expq.delete();
        for (int i = 0; i < NW; i++) expq.push_back({1'(i == NW - 1), mem[i]});
        exp_rd_addr = 0; reads = 0; beats = 0; dones = 0; lasts = 0;
        early_reads = 0; first_crd_cyc = -1; first_beat_cyc = -1;
        last_cyc = -1; done_cyc = -1; prev_stall = 1'b0;
        for (int c = 0; c < budget; c++) begin
            fc    = c;
            start = (c == 0) || (c == restart);
            case (mode)
                1:       m_ready = 1'($urandom_range(0, 1));
                2:       m_ready = (c >= 20);
                default: m_ready = 1'b1;
            endcase
            sample();
            @(negedge clk);
            if (dones > 0) break;
        end
        start = 1'b0;
        if (expect_done) begin
            chk("done_pulses", dones, 1);
            chk("beats", beats, NW);
            chk("last_beats", lasts, 1);
            chk("words_left", expq.size(), 0);
            chk("idle_after_done", busy, 0);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        start   = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < NW; i++) mem[i] = 20'(i);
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Full-rate frame with identity memory: exact cycle timing.
        frame(0, -1, 1200, 1);
        chk("first_crd_cyc",  first_crd_cyc,  1);
        chk("first_beat_cyc", first_beat_cyc, 3);
        chk("last_cyc",       last_cyc,       1026);
        chk("done_cyc",       done_cyc,       1028);

        // Random backpressure with random contents.
        for (int i = 0; i < NW; i++) mem[i] = 20'($urandom);
        frame(1, -1, 6000, 1);

        // Downstream stalled for 20 cycles: only FIFO_DEPTH reads may go out.
        frame(2, -1, 1200, 1);
        chk("early_reads", early_reads, FD);

        // Second start mid-frame must be ignored.
        frame(0, 100, 1200, 1);
        m_ready = 1'b1;
        repeat (20) begin
            sample();
            @(negedge clk);
        end
        chk("reads_after_frame", reads, NW);
        chk("dones_after_frame", dones, 1);

        // Reset at cycle 500 of a frame, then a fresh frame with new contents.
        frame(0, -1, 500, 0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_outputs_zero("abort");
        @(negedge clk);
        chk("no_stale_word", m_valid, 0);
        for (int i = 0; i < NW; i++) mem[i] = 20'hFFFFF ^ 20'(i * 7);
        frame(0, -1, 1200, 1);
        chk("restart_first_beat", first_beat_cyc, 3);
        chk("restart_done_cyc",   done_cyc,       1028);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
